slot_state_memory: RTL and testbench
====================================

// Module: slot_state_memory
// PURPOSE
//  Parametrised per-slot state store for the VM2413 operator pipeline; successor to the fixed 18x18 phase store.
//  Holds one WIDTH-bit word per slot. Separate read and write addresses; optional write-to-read bypass.
//  Self-clearing sweep after reset or on demand (clear_req), e.g. on register-bank reset or rhythm-mode change.
//  Instanced for phase, envelope and feedback state; sits between slot counter and operator/envelope stages.
// PARAMETERS
//  SLOTS       18   number of slots (>=2); address width AW = $clog2(SLOTS)
//  WIDTH       18   bits per word
//  INIT_VALUE  0    WIDTH-bit value written by the sweep and returned for invalid reads
//  BYPASS      1    1: same-cycle write to rd_slot is forwarded to rd_data; 0: rd_data returns old contents
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  clear_req  in   1      single-cycle pulse; (re)starts the init sweep
//  init_busy  out  1      1 while the sweep is running
//  rd_slot    in   AW     read address, sampled every cycle
//  rd_data    out  WIDTH  registered read data, 1-cycle latency
//  wr_en      in   1      write strobe
//  wr_slot    in   AW     write address
//  wr_data    in   WIDTH  write data
//  wr_drop    out  1      registered pulse: a write arrived and was discarded
// BEHAVIOUR
//  Reset (reset_n=0, async): init_ptr=0, init_busy=1, rd_data=INIT_VALUE, wr_drop=0. Array is NOT reset.
//  Sweep FSM: SWEEP -> IDLE.
//   SWEEP: each cycle writes INIT_VALUE to array[init_ptr], init_ptr++.
//          After writing slot SLOTS-1 -> IDLE; init_busy=0 from the next edge (SLOTS cycles after release).
//   IDLE:  clear_req=1 -> SWEEP, init_ptr=0; init_busy=1 from the next edge.
//   clear_req during SWEEP restarts at init_ptr=0; the sweep always ends with every slot cleared.
//  Writes: in IDLE, wr_en with wr_slot<SLOTS writes array[wr_slot]<=wr_data.
//   Writes during SWEEP, or with wr_slot>=SLOTS: discarded; wr_drop=1 on the next cycle.
//   The IDLE-cycle carrying clear_req still accepts its write; the sweep then overwrites it.
//  Reads (every cycle, rd_data registered):
//   init_busy=1 or rd_slot>=SLOTS -> rd_data<=INIT_VALUE.
//   BYPASS=1, accepted write with wr_slot==rd_slot -> rd_data<=wr_data.
//   Otherwise rd_data<=array[rd_slot] (value before this cycle's write).
//  No arithmetic; widths pass through unchanged. init_ptr is AW bits and never exceeds SLOTS-1.
//  Reset mid-sweep or mid-write: asynchronous abort; the sweep restarts from slot 0 on release.
// STRUCTURE
//  vm2413 package: keep SLOT_TYPE/PHASE_TYPE; add localparam NUM_SLOTS=18.
//  Default instance (SLOTS=NUM_SLOTS, WIDTH=$bits(PHASE_TYPE)) must drop in for the old phase store.
//  One sub-module: sdp_ram (simple dual-port, registered read, no reset, parameters DEPTH/WIDTH).
//   Infers block RAM. Sweep mux, bypass and range checks stay in this module.
// TESTING
//  1 Release reset, hold rd_slot=5 -> init_busy=1 for exactly 18 cycles; rd_data=0 throughout and after.
//  2 Idle: write slot 3=0x2ABCD, then read 3 -> rd_data=0x2ABCD one cycle after rd_slot is presented.
//  3 BYPASS=1: write slot 7=0x155 while rd_slot=7 -> rd_data=0x155 next cycle.
//    BYPASS=0: old value returned, 0x155 on the following read.
//  4 Write slot 9 during sweep -> wr_drop=1 next cycle; after the sweep slot 9 reads 0.
//    wr_slot=20 while idle -> wr_drop=1; rd_slot=20 -> 0.
//  5 Fill all slots, pulse clear_req at ptr=10 of a second clear -> sweep restarts;
//    busy lasts 18 cycles from the restart; all slots read 0.
//  6 Deassert reset_n mid-sweep, then release -> rd_data=0 immediately; full 18-cycle sweep repeats.
//    SLOTS=32, WIDTH=8, INIT_VALUE=0xA5: all slots read 0xA5 after 32 cycles.

Source files
------------

// File: rtl/slot_state_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slot_state_memory_pkg
// Brief    : Shared types and sizes for the VM2413 per-slot state stores.
// Revision : 1.0
// ============================================================================
package slot_state_memory_pkg;

   localparam int NUM_SLOTS = 18;

   typedef logic [4:0]  SLOT_TYPE;
   typedef logic [17:0] PHASE_TYPE;

   typedef enum logic [0:0] {
      ST_SWEEP = 1'b0,
      ST_IDLE  = 1'b1
   } sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/slot_state_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : slot_state_memory_if
// Brief    : Read/write/clear bundle between slot sequencer and state store.
// Revision : 1.0
// ============================================================================
interface slot_state_memory_if
   import slot_state_memory_pkg::*;
#(
   parameter int SLOTS = NUM_SLOTS,
   parameter int WIDTH = $bits(PHASE_TYPE)
) ();

   localparam int AW = $clog2(SLOTS);

   logic             clear_req;
   logic             init_busy;
   logic [AW-1:0]    rd_slot;
   logic [WIDTH-1:0] rd_data;
   logic             wr_en;
   logic [AW-1:0]    wr_slot;
   logic [WIDTH-1:0] wr_data;
   logic             wr_drop;

   modport master (
      output clear_req, rd_slot, wr_en, wr_slot, wr_data,
      input  init_busy, rd_data, wr_drop
   );

   modport slave (
      input  clear_req, rd_slot, wr_en, wr_slot, wr_data,
      output init_busy, rd_data, wr_drop
   );

endinterface
`default_nettype wire

// File: rtl/slot_state_memory_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : slot_state_memory_sdp_ram
// Brief    : Simple dual-port RAM, registered read-first output, no reset.
// Revision : 1.0
// ============================================================================
module slot_state_memory_sdp_ram #(
   parameter int DEPTH = 18,
   parameter int WIDTH = 18,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             we_i,
   input  wire logic [AW-1:0]    waddr_i,
   input  wire logic [WIDTH-1:0] wdata_i,
   input  wire logic [AW-1:0]    raddr_i,
   output logic      [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Read and write share one process so a same-address access returns old data.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/slot_state_memory.sv
`default_nettype none
// ============================================================================
// Module   : slot_state_memory
// Brief    : Per-slot state store with self-clearing sweep and write bypass.
// Revision : 1.0
// ============================================================================
module slot_state_memory
   import slot_state_memory_pkg::*;
#(
   parameter int               SLOTS      = NUM_SLOTS,
   parameter int               WIDTH      = $bits(PHASE_TYPE),
   parameter logic [WIDTH-1:0] INIT_VALUE = '0,
   parameter bit               BYPASS     = 1'b1
) (
   input wire logic clk,
   input wire logic reset_n,
   slot_state_memory_if.slave bus
);

   localparam int            AW      = $clog2(SLOTS);
   localparam logic [AW:0]   c_SLOTS = (AW+1)'(SLOTS);
   localparam logic [AW-1:0] c_LAST  = AW'(SLOTS - 1);

   sweep_state_e     state_q;
   logic [AW-1:0]    ptr_q;
   logic             busy_q;
   logic             rd_init_q;
   logic             rd_byp_q;
   logic [WIDTH-1:0] byp_data_q;
   logic             wr_drop_q;

   logic             w_sweep;
   logic             w_wr_in_range;
   logic             w_rd_in_range;
   logic             w_wr_accept;
   logic             w_ram_we;
   logic [AW-1:0]    w_ram_waddr;
   logic [WIDTH-1:0] w_ram_wdata;
   logic [AW-1:0]    w_ram_raddr;
   logic [WIDTH-1:0] w_ram_rdata;

   // A clear request always wins, so a restarted sweep still covers every slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_SWEEP;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_SWEEP: begin
               if (bus.clear_req) begin
                  ptr_q <= '0;
               end else if (ptr_q == c_LAST) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            ST_IDLE: begin
               if (bus.clear_req) begin
                  state_q <= ST_SWEEP;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_SWEEP;
               ptr_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign w_sweep       = (state_q == ST_SWEEP);
   assign w_wr_in_range = ({1'b0, bus.wr_slot} < c_SLOTS);
   assign w_rd_in_range = ({1'b0, bus.rd_slot} < c_SLOTS);
   assign w_wr_accept   = bus.wr_en & ~w_sweep & w_wr_in_range;

   assign w_ram_we    = w_sweep | w_wr_accept;
   assign w_ram_waddr = w_sweep ? ptr_q : bus.wr_slot;
   assign w_ram_wdata = w_sweep ? INIT_VALUE : bus.wr_data;
   assign w_ram_raddr = w_rd_in_range ? bus.rd_slot : '0;

   slot_state_memory_sdp_ram #(
      .DEPTH (SLOTS),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_ram_we),
      .waddr_i (w_ram_waddr),
      .wdata_i (w_ram_wdata),
      .raddr_i (w_ram_raddr),
      .rdata_o (w_ram_rdata)
   );

   // Output select is registered alongside the RAM read so both share one cycle of latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_init_q  <= 1'b1;
         rd_byp_q   <= 1'b0;
         byp_data_q <= INIT_VALUE;
         wr_drop_q  <= 1'b0;
      end else begin
         rd_init_q  <= w_sweep | ~w_rd_in_range;
         rd_byp_q   <= BYPASS & w_wr_accept & (bus.wr_slot == bus.rd_slot);
         byp_data_q <= bus.wr_data;
         wr_drop_q  <= bus.wr_en & ~w_wr_accept;
      end
   end

   assign bus.init_busy = busy_q;
   assign bus.wr_drop   = wr_drop_q;
   assign bus.rd_data   = rd_init_q ? INIT_VALUE : (rd_byp_q ? byp_data_q : w_ram_rdata);

endmodule
`default_nettype wire

// File: tb/tb_slot_state_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_state_memory
// Brief    : Randomised self-checking bench for slot_state_memory variants.
// Revision : 1.0
// ============================================================================
module tb_slot_state_memory;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   always #5 clk = ~clk;

   slot_state_memory_if #(.SLOTS(18), .WIDTH(18)) if0 ();
   slot_state_memory_if #(.SLOTS(18), .WIDTH(18)) if1 ();
   slot_state_memory_if #(.SLOTS(32), .WIDTH(8))  if2 ();

   slot_state_memory d0 (.clk(clk), .reset_n(reset_n), .bus(if0));
   slot_state_memory #(.BYPASS(1'b0)) d1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   slot_state_memory #(.SLOTS(32), .WIDTH(8), .INIT_VALUE(8'hA5)) d2 (
      .clk(clk), .reset_n(reset_n), .bus(if2));

   int checks = 0;
   int errors = 0;

   // Reference: contents per slot, plus "sweep in progress, next slot to clear".
   logic [17:0] mdl_mem [18];
   bit          mdl_busy;
   int          mdl_pos;
   int          mdl_left2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mdl_busy  = 1'b1;
      mdl_pos   = 0;
      mdl_left2 = 32;
   endtask

   task automatic step(input bit clr, input bit we, input int ws, input logic [17:0] wd, input int rs);
      logic [17:0] e_rd0, e_rd1;
      bit          acc, e_drop;
      if0.clear_req = clr;  if1.clear_req = clr;
      if0.wr_en     = we;   if1.wr_en     = we;
      if0.wr_slot   = 5'(ws); if1.wr_slot = 5'(ws);
      if0.wr_data   = wd;   if1.wr_data   = wd;
      if0.rd_slot   = 5'(rs); if1.rd_slot = 5'(rs);
      if2.rd_slot   = 5'($urandom_range(0, 31));

      acc    = !mdl_busy && we && (ws < 18);
      e_drop = we && !acc;
      if (mdl_busy || rs >= 18) begin
         e_rd0 = '0;
         e_rd1 = '0;
      end else begin
         e_rd1 = mdl_mem[rs];
         e_rd0 = (acc && ws == rs) ? wd : mdl_mem[rs];
      end
      if (mdl_busy) mdl_mem[mdl_pos] = '0;
      if (acc) mdl_mem[ws] = wd;
      if (clr) begin
         mdl_busy = 1'b1;
         mdl_pos  = 0;
      end else if (mdl_busy) begin
         mdl_pos++;
         if (mdl_pos == 18) begin
            mdl_busy = 1'b0;
            mdl_pos  = 0;
         end
      end
      if (mdl_left2 > 0) mdl_left2--;

      @(posedge clk);
      #1;
      check("d0_rd",   32'(if0.rd_data),   32'(e_rd0));
      check("d0_busy", 32'(if0.init_busy), 32'(mdl_busy));
      check("d0_drop", 32'(if0.wr_drop),   32'(e_drop));
      check("d1_rd",   32'(if1.rd_data),   32'(e_rd1));
      check("d1_busy", 32'(if1.init_busy), 32'(mdl_busy));
      check("d1_drop", 32'(if1.wr_drop),   32'(e_drop));
      check("d2_rd",   32'(if2.rd_data),   32'h0000_00A5);
      check("d2_busy", 32'(if2.init_busy), 32'(mdl_left2 > 0));
   endtask

   task automatic count_busy(input int rs, output int cnt);
      int guard = 0;
      cnt = if0.init_busy ? 1 : 0;
      while (if0.init_busy && guard < 64) begin
         step(1'b0, 1'b0, 0, '0, rs);
         if (if0.init_busy) cnt++;
         guard++;
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      #1;
      check("rel_rd",   32'(if0.rd_data),   32'h0);
      check("rel_busy", 32'(if0.init_busy), 32'h1);
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 18; i++) mdl_mem[i] = '0;
      model_reset();
      {if0.clear_req, if0.wr_en, if0.wr_slot, if0.wr_data, if0.rd_slot} = '0;
      {if1.clear_req, if1.wr_en, if1.wr_slot, if1.wr_data, if1.rd_slot} = '0;
      {if2.clear_req, if2.wr_en, if2.wr_slot, if2.wr_data, if2.rd_slot} = '0;

      // Power-on reset and sweep length.
      #2 reset_n = 1'b0;
      #1;
      check("rst_rd",    32'(if0.rd_data),   32'h0);
      check("rst_busy",  32'(if0.init_busy), 32'h1);
      check("rst_drop",  32'(if0.wr_drop),   32'h0);
      check("rst_rd_w8", 32'(if2.rd_data),   32'hA5);
      if0.rd_slot = 5'd5; if1.rd_slot = 5'd5;
      release_reset();
      count_busy(5, cnt);
      check("t1_busy_len", 32'(cnt), 32'd18);

      // Plain write then read.
      step(1'b0, 1'b1, 3, 18'h2ABCD, 0);
      step(1'b0, 1'b0, 0, '0, 3);
      check("t2_rd", 32'(if0.rd_data), 32'h2ABCD);

      // Same-cycle write/read of one slot: bypass vs. read-old.
      step(1'b0, 1'b1, 7, 18'h155, 7);
      check("t3_byp",  32'(if0.rd_data), 32'h155);
      check("t3_old",  32'(if1.rd_data), 32'h0);
      step(1'b0, 1'b0, 0, '0, 7);
      check("t3_new",  32'(if1.rd_data), 32'h155);

      // Writes dropped during sweep and out of range.
      step(1'b1, 1'b1, 9, 18'h3FFFF, 0);
      check("t4_clr_wr_kept", 32'(if0.wr_drop), 32'h0);
      step(1'b0, 1'b1, 9, 18'h01111, 0);
      check("t4_sweep_drop", 32'(if0.wr_drop), 32'h1);
      count_busy(0, cnt);
      step(1'b0, 1'b0, 0, '0, 9);
      check("t4_rd9", 32'(if0.rd_data), 32'h0);
      step(1'b0, 1'b1, 20, 18'h2AAAA, 0);
      check("t4_oor_drop", 32'(if0.wr_drop), 32'h1);
      step(1'b0, 1'b0, 0, '0, 20);
      check("t4_oor_rd", 32'(if0.rd_data), 32'h0);

      // Fill, clear, restart the clear at pointer 10.
      for (int i = 0; i < 18; i++) step(1'b0, 1'b1, i, 18'($urandom), $urandom_range(0, 21));
      step(1'b1, 1'b0, 0, '0, 0);
      repeat (10) step(1'b0, 1'b0, 0, '0, 0);
      step(1'b1, 1'b0, 0, '0, 0);
      count_busy(0, cnt);
      check("t5_busy_len", 32'(cnt), 32'd18);
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 1'b0, 0, '0, i);
         check("t5_clr_rd", 32'(if0.rd_data), 32'h0);
      end

      // Reset in the middle of a sweep.
      for (int i = 0; i < 18; i++) step(1'b0, 1'b1, i, 18'($urandom), 0);
      step(1'b1, 1'b0, 0, '0, 0);
      repeat (5) step(1'b0, 1'b0, 0, '0, 4);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_rd",   32'(if0.rd_data),   32'h0);
      check("t6_rst_busy", 32'(if0.init_busy), 32'h1);
      release_reset();
      count_busy(5, cnt);
      check("t6_busy_len", 32'(cnt), 32'd18);
      repeat (20) step(1'b0, 1'b0, 0, '0, $urandom_range(0, 17));
      check("t6_w8_idle", 32'(if2.init_busy), 32'h0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         int ws, rs;
         ws = $urandom_range(0, 21);
         rs = ($urandom_range(0, 3) == 0) ? ws : $urandom_range(0, 21);
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, ws, 18'($urandom), rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
